// File: rtl/fetch_unit.sv
// Instruction-fetch stage and IF/ID pipeline register with decode-stall hold buffer.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        redirect_D,
    input  logic [31:0] target_D,
    input  logic        mispredict_E,
    input  logic [31:0] restore_PC_E,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] PC_D,
    output logic [31:0] PCPlus4_D,
    output logic        valid_D,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
);

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] pc_d_q, pc_d_d;
    logic        valid_d_q, valid_d_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;

    always_comb begin
        pc_f_d = pc_f_q + 32'd4;
        if (mispredict_E) begin
            pc_f_d = restore_PC_E & ALIGN_MASK;
        end else if (StallF) begin
            pc_f_d = pc_f_q;
        end else if (redirect_D) begin
            pc_f_d = target_D & ALIGN_MASK;
        end
    end

    // A squash keeps PC_D so that a bubble still reports the last decode PC.
    always_comb begin
        pc_d_d    = pc_d_q;
        valid_d_d = valid_d_q;
        if (FlushD || mispredict_E) begin
            valid_d_d = 1'b0;
        end else if (!StallD) begin
            pc_d_d    = pc_f_q;
            valid_d_d = 1'b1;
        end
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        if (!StallD || FlushD || mispredict_E) begin
            hold_valid_d = 1'b0;
        end else if (valid_d_q && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_instr_d = imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q       <= RESET_PC;
            pc_d_q       <= 32'h0;
            valid_d_q    <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_instr_q <= NOP_INSTR;
        end else begin
            pc_f_q       <= pc_f_d;
            pc_d_q       <= pc_d_d;
            valid_d_q    <= valid_d_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    always_comb begin
        instr_D = imem_rdata;
        if (!valid_d_q) begin
            instr_D = NOP_INSTR;
        end else if (hold_valid_q) begin
            instr_D = hold_instr_q;
        end
    end

    assign imem_addr = pc_f_q;
    assign imem_req  = !reset;
    assign PC_D      = pc_d_q;
    assign PCPlus4_D = pc_d_q + 32'd4;
    assign valid_D   = valid_d_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (valid_d_q && !StallD) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (!valid_d_q) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`else
    assign perf_fetch_cnt  = 32'h0;
    assign perf_bubble_cnt = 32'h0;
`endif

endmodule
